// File: rtl/live_program_store_pkg.sv
// Shared RVC definitions for the live program store.
// Constants, FSM encoding and encoders reused by loaders and benches.
package live_program_store_pkg;

    localparam logic [15:0] RVC_NOP = 16'h0001;

    localparam logic [1:0] OP_C0 = 2'b00;
    localparam logic [1:0] OP_C1 = 2'b01;
    localparam logic [1:0] OP_C2 = 2'b10;

    localparam logic [2:0] F3_JAL  = 3'b001;
    localparam logic [2:0] F3_LI   = 3'b010;
    localparam logic [2:0] F3_MVAD = 3'b100;
    localparam logic [2:0] F3_J    = 3'b101;
    localparam logic [2:0] F3_BEQZ = 3'b110;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    function automatic logic [15:0] c_li(
        input logic [4:0] rd,
        input logic [5:0] imm
    );
        return {F3_LI, imm[5], rd, imm[4:0], OP_C1};
    endfunction

    function automatic logic [15:0] c_mv(
        input logic [4:0] rd,
        input logic [4:0] rs2
    );
        return {F3_MVAD, 1'b0, rd, rs2, OP_C2};
    endfunction

    function automatic logic [15:0] c_add(
        input logic [4:0] rd,
        input logic [4:0] rs2
    );
        return {F3_MVAD, 1'b1, rd, rs2, OP_C2};
    endfunction

    // Shared CJ-format immediate scramble for c.j / c.jal.
    function automatic logic [10:0] cj_imm(input logic [11:0] off);
        return {off[11], off[4], off[9:8], off[10],
                off[6], off[7], off[3:1], off[5]};
    endfunction

    function automatic logic [15:0] c_j(input logic [11:0] off);
        return {F3_J, cj_imm(off), OP_C1};
    endfunction

    function automatic logic [15:0] c_jal(input logic [11:0] off);
        return {F3_JAL, cj_imm(off), OP_C1};
    endfunction

    function automatic logic [15:0] c_beqz(
        input logic [2:0] rs1p,
        input logic [8:0] off
    );
        return {F3_BEQZ, off[8], off[4:3], rs1p,
                off[7:6], off[2:1], off[5], OP_C1};
    endfunction

endpackage

// File: rtl/live_program_store_if.sv
// Fetch and program port bundle of the live program store.
// Master is the core/loader side, slave is the store.
interface live_program_store_if #(
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);

    logic          fetch_valid;
    logic [31:0]   fetch_addr;
    logic          fetch_ready;
    logic          inst_valid;
    logic [15:0]   instruction;
    logic          inst_fault;
    logic          inst_ready;
    logic          prog_write;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic          prog_clear;
    logic          prog_ready;

    modport master (
        output fetch_valid, fetch_addr, inst_ready,
        output prog_write, prog_addr, prog_data, prog_clear,
        input  fetch_ready, inst_valid, instruction,
        input  inst_fault, prog_ready
    );

    modport slave (
        input  fetch_valid, fetch_addr, inst_ready,
        input  prog_write, prog_addr, prog_data, prog_clear,
        output fetch_ready, inst_valid, instruction,
        output inst_fault, prog_ready
    );

endinterface

// File: rtl/live_program_store_program_ram.sv
// Simple dual-port halfword RAM with write-first read bypass.
// One synchronous write and one synchronous read per cycle.
module program_ram #(
    parameter int DEPTH = 256,
    parameter int W     = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port; a same-index write in the same cycle wins.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/live_program_store.sv
// Writable RVC program store: clear sweep FSM, fault decode
// and single-entry fetch output register with valid/ready.
module live_program_store
    import live_program_store_pkg::*;
#(
    parameter int          DEPTH = 256,
    parameter logic [15:0] FILL  = RVC_NOP,
    localparam int         AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    live_program_store_if.slave  bus
);

    state_t        state;
    logic [AW-1:0] clear_idx;
    logic          prog_ready_q;
    logic          inst_valid_q;
    logic          inst_fault_q;
    logic          use_ram_q;

    logic          fault;
    logic          accept;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;

    assign fault   = bus.fetch_addr[0] | (|bus.fetch_addr[31:AW+1]);
    assign rd_addr = bus.fetch_addr[AW:1];

    assign bus.fetch_ready = (state == ST_RUN) &
                             (!inst_valid_q | bus.inst_ready);
    assign accept = bus.fetch_valid & bus.fetch_ready;
    assign rd_en  = accept & !fault;

    assign bus.inst_valid  = inst_valid_q;
    assign bus.inst_fault  = inst_fault_q;
    assign bus.instruction = use_ram_q ? rd_data : FILL;
    assign bus.prog_ready  = prog_ready_q;

    // Write port owner: clear sweep in CLEAR, program port in RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clear_idx;
        wr_data = FILL;
        unique case (state)
            ST_CLEAR: begin
                wr_en = 1'b1;
            end
            ST_RUN: begin
                wr_en   = bus.prog_write & !bus.prog_clear;
                wr_addr = bus.prog_addr;
                wr_data = bus.prog_data;
            end
            default: ;
        endcase
    end

    // CLEAR/RUN sequencer with clear counter and program-ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_CLEAR;
            clear_idx    <= '0;
            prog_ready_q <= 1'b0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    clear_idx <= clear_idx + AW'(1);
                    if (clear_idx == AW'(DEPTH - 1)) begin
                        state        <= ST_RUN;
                        prog_ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.prog_clear) begin
                        state        <= ST_CLEAR;
                        clear_idx    <= '0;
                        prog_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_CLEAR;
                    clear_idx    <= '0;
                    prog_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Fetch result register: load on accept, drop on consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_valid_q <= 1'b0;
            inst_fault_q <= 1'b0;
            use_ram_q    <= 1'b0;
        end else if (accept) begin
            inst_valid_q <= 1'b1;
            inst_fault_q <= fault;
            use_ram_q    <= !fault;
        end else if (bus.inst_ready) begin
            inst_valid_q <= 1'b0;
        end
    end

    program_ram #(
        .DEPTH (DEPTH),
        .W     (16)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_live_program_store.sv
// Scoreboard bench for live_program_store: directed scenarios
// followed by random fetch/program traffic against a memory model.
module tb_live_program_store;
    import live_program_store_pkg::*;

    localparam int          DEPTH = 256;
    localparam int          AW    = 8;
    localparam logic [15:0] FILL  = 16'h0001;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    live_program_store_if #(.DEPTH(DEPTH)) bus ();

    live_program_store #(
        .DEPTH (DEPTH),
        .FILL  (FILL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [16:0] exp_q [$];
    logic [15:0] mem [DEPTH];
    int          clear_left;
    bit          mvalid;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        clear_left = DEPTH;
        mvalid     = 1'b0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) mem[i] = FILL;
    endtask

    task automatic idle();
        bus.fetch_valid = 1'b0;
        bus.fetch_addr  = 32'h0;
        bus.inst_ready  = 1'b1;
        bus.prog_write  = 1'b0;
        bus.prog_addr   = '0;
        bus.prog_data   = 16'h0;
        bus.prog_clear  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = a;
    endtask

    task automatic pwrite(input int idx, input logic [15:0] d);
        bus.prog_write = 1'b1;
        bus.prog_addr  = AW'(idx);
        bus.prog_data  = d;
    endtask

    // One clock of the reference model; inputs are already driven.
    task automatic step();
        logic        rdy;
        logic        acc;
        logic        wr_eff;
        logic [31:0] a;
        int          idx;
        @(negedge clk);
        rdy = (clear_left == 0) && (!mvalid || bus.inst_ready);
        chk("fetch_ready", 32'(bus.fetch_ready), 32'(rdy));
        chk("prog_ready", 32'(bus.prog_ready), 32'(clear_left == 0));
        chk("inst_valid", 32'(bus.inst_valid), 32'(mvalid));
        wr_eff = (clear_left == 0) && bus.prog_write && !bus.prog_clear;
        acc = bus.fetch_valid && rdy;
        if (acc) begin
            a   = bus.fetch_addr;
            idx = int'(a[AW:1]);
            if (a[0] || (a >> (AW + 1)) != 0)
                exp_q.push_back({1'b1, FILL});
            else if (wr_eff && int'(bus.prog_addr) == idx)
                exp_q.push_back({1'b0, bus.prog_data});
            else
                exp_q.push_back({1'b0, mem[idx]});
        end
        if (clear_left > 0) begin
            clear_left--;
        end else if (bus.prog_clear) begin
            clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mem[i] = FILL;
        end else if (bus.prog_write) begin
            mem[int'(bus.prog_addr)] = bus.prog_data;
        end
        if (acc) mvalid = 1'b1;
        else if (bus.inst_ready) mvalid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'(0));
        chk({tag, "_instruction"}, 32'(bus.instruction), 32'(FILL));
        chk({tag, "_inst_fault"}, 32'(bus.inst_fault), 32'(0));
        chk({tag, "_fetch_ready"}, 32'(bus.fetch_ready), 32'(0));
        chk({tag, "_prog_ready"}, 32'(bus.prog_ready), 32'(0));
    endtask

    // Monitor: any presented result must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.inst_valid) begin
            if (exp_q.size() == 0) begin
                chk("result_unexpected", 32'({bus.inst_fault,
                    bus.instruction}), 32'h1_FFFF);
            end else begin
                chk("result", 32'({bus.inst_fault, bus.instruction}),
                    32'(exp_q[0]));
                if (bus.inst_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        #1;
        chk_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        while (clear_left > 0) step();

        fetch(32'h0);
        step();
        fetch(32'h1FE);
        step();
        idle();
        step();

        pwrite(1, c_li(5'd8, 6'd0));
        step();
        pwrite(2, c_mv(5'd10, 5'd8));
        step();
        idle();
        chk("enc_c_li", 32'(c_li(5'd8, 6'd0)), 32'h4401);
        chk("enc_c_mv", 32'(c_mv(5'd10, 5'd8)), 32'h8522);

        fetch(32'h2);
        step();
        fetch(32'h4);
        step();
        idle();
        step();

        fetch(32'h2);
        step();
        fetch(32'h4);
        bus.inst_ready = 1'b0;
        repeat (3) step();
        bus.inst_ready = 1'b1;
        step();
        idle();
        step();

        fetch(32'h3);
        step();
        fetch(32'h200);
        step();
        idle();
        step();

        pwrite(5, 16'hBEEF);
        fetch(32'hA);
        step();
        idle();
        step();

        bus.prog_clear = 1'b1;
        step();
        bus.prog_clear = 1'b0;
        fetch(32'h2);
        while (clear_left > 0) step();
        step();
        idle();
        step();

        fetch(32'h2);
        bus.inst_ready = 1'b0;
        step();
        bus.fetch_valid = 1'b0;
        bus.prog_clear  = 1'b1;
        step();
        bus.prog_clear = 1'b0;
        repeat (100) step();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk_reset_outputs("mid_sweep");
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        while (clear_left > 0) step();

        for (int i = 0; i < 3000; i++) begin
            int r;
            bus.fetch_valid = ($urandom % 4) != 0;
            r = int'($urandom % 16);
            if (r < 10)
                bus.fetch_addr = 32'($urandom_range(0, 15)) << 1;
            else if (r < 13)
                bus.fetch_addr = ($urandom % (2 * DEPTH)) & ~32'h1;
            else if (r < 14)
                bus.fetch_addr = ($urandom % (2 * DEPTH)) | 32'h1;
            else
                bus.fetch_addr = $urandom;
            bus.inst_ready = ($urandom % 4) != 0;
            bus.prog_write = ($urandom % 3) == 0;
            if (($urandom % 4) != 0)
                bus.prog_addr = AW'($urandom_range(0, 15));
            else
                bus.prog_addr = AW'($urandom);
            bus.prog_data  = 16'($urandom);
            bus.prog_clear = ($urandom % 800) == 0;
            step();
        end

        idle();
        repeat (4) step();
        chk("drain", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
